// File: rtl/pipeline_hazard_ctrl_if.sv
// Control/status bundle between the datapath and the pipeline hazard controller.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [6:0]       id_opcode;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             ex_mispredict;
    logic             mem_busy;
    logic             clear_counts;
    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_bubble;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             redirect;
    logic             freeze;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_opcode, id_rs1, id_rs2, ex_rd, ex_mem_read, ex_mispredict, mem_busy,
               clear_counts,
        input  pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, redirect, freeze,
               stall_count, flush_count
    );

    modport slave (
        input  id_opcode, id_rs1, id_rs2, ex_rd, ex_mem_read, ex_mispredict, mem_busy,
               clear_counts,
        output pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, redirect, freeze,
               stall_count, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for a 5-stage RISC-V pipeline: load-use bubbles, mispredict squash,
// memory-busy freeze, and saturating stall/flush event counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned FLUSH_LEN = 2,
    parameter int unsigned CNT_W     = 16
) (
    input logic                  clk,
    input logic                  reset,
    pipeline_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {StRun = 2'd0, StStall = 2'd1, StFlush = 2'd2} state_e;

    localparam logic [3:0] FlushInit = 4'(FLUSH_LEN - 1);

    state_e           state_q, state_d;
    logic [3:0]       flush_left_q, flush_left_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    logic uses_rs1, uses_rs2, load_use;
    logic stall_inc, flush_inc;
    logic pc_write_c, if_id_write_c, id_ex_bubble_c, if_id_flush_c, id_ex_flush_c;
    logic redirect_c, freeze_c;

    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        unique case (hz.id_opcode)
            7'b0110011, 7'b0100011, 7'b1100011: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            7'b0010011, 7'b0000011: uses_rs1 = 1'b1;
            default: ;
        endcase
    end

    assign load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
                      ((uses_rs1 && (hz.ex_rd == hz.id_rs1)) ||
                       (uses_rs2 && (hz.ex_rd == hz.id_rs2)));

    always_comb begin
        state_d        = state_q;
        flush_left_d   = flush_left_q;
        pc_write_c     = 1'b1;
        if_id_write_c  = 1'b1;
        id_ex_bubble_c = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_flush_c  = 1'b0;
        redirect_c     = 1'b0;
        freeze_c       = 1'b0;
        stall_inc      = 1'b0;
        flush_inc      = 1'b0;

        if (hz.mem_busy) begin
            // EX is frozen, so any mispredict/load-use is seen again once memory is ready.
            freeze_c      = 1'b1;
            pc_write_c    = 1'b0;
            if_id_write_c = 1'b0;
        end else if (hz.ex_mispredict) begin
            redirect_c    = 1'b1;
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
            flush_inc     = 1'b1;
            if (FLUSH_LEN > 1) begin
                state_d      = StFlush;
                flush_left_d = FlushInit;
            end else begin
                state_d      = StRun;
                flush_left_d = 4'd0;
            end
        end else begin
            unique case (state_q)
                StFlush: begin
                    if_id_flush_c = 1'b1;
                    flush_left_d  = flush_left_q - 4'd1;
                    if (flush_left_q <= 4'd1) begin
                        state_d      = StRun;
                        flush_left_d = 4'd0;
                    end
                end
                StStall: state_d = StRun;
                StRun: begin
                    if (load_use) begin
                        pc_write_c     = 1'b0;
                        if_id_write_c  = 1'b0;
                        id_ex_bubble_c = 1'b1;
                        stall_inc      = 1'b1;
                        state_d        = StStall;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (hz.clear_counts) begin
            stall_count_d = '0;
            flush_count_d = '0;
        end else begin
            if (stall_inc && (stall_count_q != '1)) stall_count_d = stall_count_q + CNT_W'(1);
            if (flush_inc && (flush_count_q != '1)) flush_count_d = flush_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StRun;
            flush_left_q  <= 4'd0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            flush_left_q  <= flush_left_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    // All control outputs are forced low for the whole time reset is held.
    assign hz.pc_write     = reset & pc_write_c;
    assign hz.if_id_write  = reset & if_id_write_c;
    assign hz.id_ex_bubble = reset & id_ex_bubble_c;
    assign hz.if_id_flush  = reset & if_id_flush_c;
    assign hz.id_ex_flush  = reset & id_ex_flush_c;
    assign hz.redirect     = reset & redirect_c;
    assign hz.freeze       = reset & freeze_c;
    assign hz.stall_count  = stall_count_q;
    assign hz.flush_count  = flush_count_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with FLUSH_LEN=3 and CNT_W=2.
module tb_pipeline_hazard_ctrl;
    localparam int unsigned FLUSH_LEN = 3;
    localparam int unsigned CNT_W     = 2;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz_if ();

    pipeline_hazard_ctrl #(
        .FLUSH_LEN(FLUSH_LEN),
        .CNT_W    (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .hz   (hz_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hz_if.id_opcode     = 7'b0110011;
        hz_if.id_rs1        = 5'd1;
        hz_if.id_rs2        = 5'd2;
        hz_if.ex_rd         = 5'd0;
        hz_if.ex_mem_read   = 1'b0;
        hz_if.ex_mispredict = 1'b0;
        hz_if.mem_busy      = 1'b0;
        hz_if.clear_counts  = 1'b0;
    endtask

    // EX: lw x5 ; ID: add x6,x5,x7
    task automatic load_use_inputs();
        hz_if.id_opcode   = 7'b0110011;
        hz_if.id_rs1      = 5'd5;
        hz_if.id_rs2      = 5'd7;
        hz_if.ex_rd       = 5'd5;
        hz_if.ex_mem_read = 1'b1;
    endtask

    // Outputs as {pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, redirect, freeze}
    function automatic logic [31:0] ctl();
        return {25'd0, hz_if.pc_write, hz_if.if_id_write, hz_if.id_ex_bubble, hz_if.if_id_flush,
                hz_if.id_ex_flush, hz_if.redirect, hz_if.freeze};
    endfunction

    localparam logic [31:0] CtlDef    = 32'b1100000;
    localparam logic [31:0] CtlStall  = 32'b0010000;
    localparam logic [31:0] CtlRedir  = 32'b1101110;
    localparam logic [31:0] CtlSquash = 32'b1101000;
    localparam logic [31:0] CtlFreeze = 32'b0000001;
    localparam logic [31:0] CtlZero   = 32'b0000000;

    initial begin
        errors = 0;
        checks = 0;
        idle();
        reset = 1'b0;
        #1;
        check("reset_outputs", ctl(), CtlZero);
        cyc();
        check("reset_stall_cnt", 32'(hz_if.stall_count), 0);
        check("reset_flush_cnt", 32'(hz_if.flush_count), 0);
        reset = 1'b1;
        #1;
        check("run_defaults", ctl(), CtlDef);
        cyc();

        // Load-use: one bubble, then defaults while the same ID instruction is held.
        load_use_inputs();
        #1;
        check("load_use_bubble", ctl(), CtlStall);
        cyc();
        check("stall_masked", ctl(), CtlDef);
        check("stall_cnt_1", 32'(hz_if.stall_count), 1);
        idle();
        cyc();

        // No false hazards.
        hz_if.ex_mem_read = 1'b1;
        hz_if.ex_rd       = 5'd0;
        hz_if.id_rs1      = 5'd0;
        #1;
        check("no_stall_x0", ctl(), CtlDef);
        hz_if.id_opcode = 7'b0010011;
        hz_if.id_rs1    = 5'd3;
        hz_if.id_rs2    = 5'd5;
        hz_if.ex_rd     = 5'd5;
        #1;
        check("no_stall_itype_rs2", ctl(), CtlDef);
        cyc();
        check("stall_cnt_still_1", 32'(hz_if.stall_count), 1);
        idle();

        // Mispredict, FLUSH_LEN=3; load-use during flush must be masked.
        hz_if.ex_mispredict = 1'b1;
        #1;
        check("mp_cycle0", ctl(), CtlRedir);
        cyc();
        hz_if.ex_mispredict = 1'b0;
        load_use_inputs();
        #1;
        check("mp_cycle1", ctl(), CtlSquash);
        check("flush_cnt_1", 32'(hz_if.flush_count), 1);
        cyc();
        idle();
        #1;
        check("mp_cycle2", ctl(), CtlSquash);
        cyc();
        check("mp_cycle3", ctl(), CtlDef);
        check("flush_masks_lu", 32'(hz_if.stall_count), 1);

        // mem_busy over mispredict for two cycles.
        hz_if.mem_busy      = 1'b1;
        hz_if.ex_mispredict = 1'b1;
        #1;
        check("busy_freeze0", ctl(), CtlFreeze);
        cyc();
        check("busy_freeze1", ctl(), CtlFreeze);
        check("busy_flush_cnt_hold", 32'(hz_if.flush_count), 1);
        cyc();
        hz_if.mem_busy = 1'b0;
        #1;
        check("busy_then_redirect", ctl(), CtlRedir);
        cyc();
        check("busy_flush_cnt_2", 32'(hz_if.flush_count), 2);
        idle();
        cyc();
        cyc();
        check("busy_flush_done", ctl(), CtlDef);

        // Load-use together with mispredict: flush wins.
        load_use_inputs();
        hz_if.ex_mispredict = 1'b1;
        #1;
        check("lu_mp_flush_wins", ctl(), CtlRedir);
        cyc();
        check("lu_mp_stall_cnt", 32'(hz_if.stall_count), 1);
        check("lu_mp_flush_cnt", 32'(hz_if.flush_count), 3);
        idle();
        cyc();
        cyc();

        // Flush counter saturates at 3.
        hz_if.ex_mispredict = 1'b1;
        cyc();
        idle();
        check("flush_cnt_sat", 32'(hz_if.flush_count), 3);
        cyc();
        cyc();
        check("sat_flush_done", ctl(), CtlDef);

        // Four more load-use events saturate the stall counter.
        for (int i = 0; i < 4; i++) begin
            load_use_inputs();
            #1;
            check("lu_loop_bubble", ctl(), CtlStall);
            cyc();
            idle();
            cyc();
        end
        check("stall_cnt_sat", 32'(hz_if.stall_count), 3);

        // Clear beats a same-cycle increment.
        load_use_inputs();
        hz_if.clear_counts = 1'b1;
        #1;
        check("clear_lu_bubble", ctl(), CtlStall);
        cyc();
        check("clear_stall_cnt", 32'(hz_if.stall_count), 0);
        check("clear_flush_cnt", 32'(hz_if.flush_count), 0);
        idle();
        cyc();

        // Reset in flush cycle 1.
        hz_if.ex_mispredict = 1'b1;
        cyc();
        hz_if.ex_mispredict = 1'b0;
        #1;
        check("pre_reset_squash", ctl(), CtlSquash);
        reset = 1'b0;
        #1;
        check("mid_flush_reset_out", ctl(), CtlZero);
        check("mid_flush_reset_cnt", 32'(hz_if.flush_count), 0);
        cyc();
        reset = 1'b1;
        #1;
        check("post_reset_defaults", ctl(), CtlDef);
        cyc();
        check("no_residual_flush", ctl(), CtlDef);
        check("post_reset_stall_cnt", 32'(hz_if.stall_count), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
